// File: rtl/binary_gcd_unit_pkg.sv
// Shared definitions for the binary GCD engine: default width, the
// power-of-two counter width and the FSM state encoding.
package binary_gcd_unit_pkg;

   // Default operand / result width.
   localparam int W_DEFAULT = 8;

   // Width of the shared power-of-two counter k. For W=8 the largest
   // common power of two among nonzero operands is 2^7, so 3 bits suffice.
   localparam int K_W = 3;

   // Engine states, 3-bit binary encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FACTOR = 3'd1,
      ST_REDUCE = 3'd2,
      ST_SCALE  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/gcd_shift_stage.sv
// Combinational one-position shifter with a serial-in bit.
// left only  : q = {d[W-2:0], si}
// right only : q = {si, d[W-1:1]}
// neither or both set: pass-through.
module gcd_shift_stage #(
   parameter int W = 8
) (
   input  logic         si,
   input  logic         left,
   input  logic         right,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Select the shifted or unshifted operand.
   always_comb begin
      q = d;
      if (left && !right) begin
         q = {d[W-2:0], si};
      end else if (right && !left) begin
         q = {si, d[W-1:1]};
      end
   end

endmodule

// File: rtl/binary_gcd_unit.sv
// Sequential GCD engine using Stein's binary algorithm. One shift,
// compare or subtract step per clock. All outputs are registered.
//
// Handshake: start is sampled only in IDLE; the cycle after acceptance
// busy rises and stays high through the single-cycle done pulse, at which
// point gcd is valid. gcd holds until the next result is written. start
// outside IDLE is ignored, never queued.
module binary_gcd_unit
   import binary_gcd_unit_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] gcd
);

   localparam logic [K_W-1:0] K_ONE = K_W'(1);

   state_t          state;
   logic [W-1:0]    ra;
   logic [W-1:0]    rb;
   logic [K_W-1:0]  k;

   // Shifter controls and results.
   logic            a_left;
   logic            a_right;
   logic [W-1:0]    sh_a;
   logic [W-1:0]    sh_b;

   // Comparator / subtractor results.
   logic            a_eq_b;
   logic            a_gt_b;
   logic [W-1:0]    diff_ab;
   logic [W-1:0]    diff_ba;

   // Left shift only doubles the result in SCALE; right shifts halve
   // operands in FACTOR and REDUCE.
   always_comb begin
      a_left  = (state == ST_SCALE);
      a_right = (state == ST_FACTOR) || (state == ST_REDUCE);
   end

   gcd_shift_stage #(.W(W)) u_shift_a (
      .si    (1'b0),
      .left  (a_left),
      .right (a_right),
      .d     (ra),
      .q     (sh_a)
   );

   gcd_shift_stage #(.W(W)) u_shift_b (
      .si    (1'b0),
      .left  (1'b0),
      .right (a_right),
      .d     (rb),
      .q     (sh_b)
   );

   // Magnitude compare and both subtraction directions; the larger
   // operand is always the minuend, so no underflow is ever selected.
   always_comb begin
      a_eq_b  = (ra == rb);
      a_gt_b  = (ra > rb);
      diff_ab = ra - rb;
      diff_ba = rb - ra;
   end

   // Control FSM with registered outputs; reset aborts any computation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ra    <= '0;
         rb    <= '0;
         k     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         gcd   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ra   <= a;
                  rb   <= b;
                  k    <= '0;
                  busy <= 1'b1;
                  if ((a == '0) || (b == '0)) begin
                     // gcd(x,0) = x, and gcd(0,0) = 0.
                     state <= ST_DONE;
                     done  <= 1'b1;
                     gcd   <= a | b;
                  end else begin
                     state <= ST_FACTOR;
                  end
               end
            end

            ST_FACTOR: begin
               if (!ra[0] && !rb[0]) begin
                  ra <= sh_a;
                  rb <= sh_b;
                  k  <= k + K_ONE;
               end else begin
                  state <= ST_REDUCE;
               end
            end

            ST_REDUCE: begin
               if (!ra[0]) begin
                  ra <= sh_a;
               end else if (!rb[0]) begin
                  rb <= sh_b;
               end else if (a_eq_b) begin
                  state <= ST_SCALE;
               end else if (a_gt_b) begin
                  ra <= diff_ab;
               end else begin
                  rb <= diff_ba;
               end
            end

            ST_SCALE: begin
               if (k != '0) begin
                  ra <= sh_a;
                  k  <= k - K_ONE;
               end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  gcd   <= ra;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binary_gcd_unit.sv
// Directed bench for binary_gcd_unit: hand-computed vectors, a spurious
// start during a run, a mid-run reset, and a sampled sweep against a
// Euclid reference.
module tb_binary_gcd_unit;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] gcd;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   logic [W-1:0] exp_q[$];

   binary_gcd_unit #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .gcd   (gcd)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] p, q, t;
      p = x;
      q = y;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // Scoreboard: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            check("gcd", 32'(gcd), 32'(exp_q.pop_front()));
         end
      end
   end

   // Issue one request and follow it to completion. inj > 0 pulses a
   // second start (9/6) at that cycle, which must be ignored.
   task automatic do_req(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] expv, input int inj);
      int  lat;
      bit  got;
      bit  busy_ok;
      int  n0;
      n0 = done_cnt;
      @(negedge clk);
      a     = va;
      b     = vb;
      start = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk);             // acceptance edge, cycle 0
      #1 start = 1'b0;
      lat     = 0;
      got     = 1'b0;
      busy_ok = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);          // mid-cycle i
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (i == inj) begin
            start = 1'b1;
            a     = 8'd9;
            b     = 8'd6;
         end
         if (i == inj + 1) start = 1'b0;
         if (done === 1'b1) begin
            lat = i;
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      check("busy_span", 32'(busy_ok), 32'd1);
      if (got) check("latency_le48", 32'(lat <= 48), 32'd1);
      if ((va == 0) || (vb == 0)) check("zero_latency", 32'(lat), 32'd1);
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      check("done_count", 32'(done_cnt - n0), 32'd1);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_gcd", 32'(gcd), 32'd0);

      // Directed vectors with hand-computed results.
      do_req(8'd48,  8'd18,  8'd6,   0);
      do_req(8'd0,   8'd37,  8'd37,  0);
      do_req(8'd0,   8'd0,   8'd0,   0);
      do_req(8'd128, 8'd96,  8'd32,  0);
      do_req(8'd255, 8'd255, 8'd255, 0);
      do_req(8'd17,  8'd13,  8'd1,   0);
      do_req(8'd37,  8'd0,   8'd37,  0);
      do_req(8'd1,   8'd255, 8'd1,   0);
      do_req(8'd128, 8'd128, 8'd128, 0);
      do_req(8'd252, 8'd198, 8'd18,  0);

      // Stray start with different operands during a run is ignored.
      do_req(8'd48, 8'd18, 8'd6, 3);
      check("gcd_hold", 32'(gcd), 32'd6);

      // Reset in cycle 4 of 200/150 aborts the request.
      begin
         int n0;
         n0 = done_cnt;
         @(negedge clk);
         a     = 8'd200;
         b     = 8'd150;
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         repeat (4) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_done", 32'(done), 32'd0);
         check("abort_gcd", 32'(gcd), 32'd0);
         repeat (60) @(negedge clk);
         check("abort_no_done", 32'(done_cnt - n0), 32'd0);
      end
      do_req(8'd200, 8'd150, 8'd50, 0);

      // Sampled sweep against the Euclid reference.
      for (int ia = 0; ia < 256; ia += 51) begin
         for (int ib = 0; ib < 256; ib += 37) begin
            do_req(W'(ia), W'(ib), ref_gcd(W'(ia), W'(ib)), 0);
         end
      end
      for (int n = 0; n < 150; n++) begin
         logic [W-1:0] ra_v, rb_v;
         ra_v = W'($urandom_range(0, 255));
         rb_v = W'($urandom_range(0, 255));
         do_req(ra_v, rb_v, ref_gcd(ra_v, rb_v), 0);
      end

      repeat (2) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
